// File: rtl/alu_mc.sv
// alu_mc: multi-cycle unsigned ALU with single-cycle logic/arith and iterative MUL/DIVU/REMU
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010, OP_MUL = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100, OP_REM = 3'b101, OP_SUB = 3'b110, OP_SLT = 3'b111;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    // x: multiplicand / dividend-quotient shifter, y: multiplier / divisor, acc: product / remainder
    logic [WIDTH-1:0] x, y, acc, quick, mul_next, rem_next, quo_next;
    logic [WIDTH:0] shifted, diff;
    logic [CW-1:0] cnt;
    logic [2:0] op;
    logic eq, multi, accept, last;
    always_comb begin
        quick = ALUControl == OP_AND ? a & b :
                ALUControl == OP_OR  ? a | b :
                ALUControl == OP_ADD ? a + b :
                ALUControl == OP_SUB ? a - b :
                ALUControl == OP_SLT ? {{(WIDTH-1){1'b0}}, a < b} : '0;
        multi = ALUControl == OP_MUL || ALUControl == OP_DIV || ALUControl == OP_REM;
        accept = start && state != RUN;
        last = cnt == CW'(1);
        mul_next = acc + (y[0] ? x : '0);
        // partial remainder is only WIDTH bits wide at rest; the shifted copy needs one more
        shifted = {acc, x[WIDTH-1]};
        diff = shifted - {1'b0, y};
        rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_next = {x[WIDTH-2:0], ~diff[WIDTH]};
    end
    assign busy = state == RUN;
    assign done = state == DONE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            x <= '0;
            y <= '0;
            acc <= '0;
            op <= '0;
            eq <= 1'b0;
            res <= '0;
            zero <= 1'b0;
        end else if (accept) begin
            op <= ALUControl;
            eq <= a == b;
            if (multi) begin
                state <= RUN;
                cnt <= CW'(WIDTH);
                x <= a;
                y <= b;
                acc <= '0;
            end else begin
                state <= DONE;
                res <= quick;
                zero <= a == b;
            end
        end else if (state == RUN) begin
            cnt <= cnt - 1'b1;
            if (op == OP_MUL) begin
                acc <= mul_next;
                x <= x << 1;
                y <= y >> 1;
            end else begin
                acc <= rem_next;
                x <= quo_next;
            end
            if (last) begin
                state <= DONE;
                res <= op == OP_MUL ? mul_next : op == OP_REM ? rem_next : quo_next;
                zero <= eq;
            end
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized and directed checks of alu_mc against an arithmetic reference model
module tb_alu_mc;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [2:0] ALUControl = '0;
    logic [31:0] a = '0, b = '0, res;
    logic zero, busy, done;
    int tests = 0, fails = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl),
        .a(a), .b(b), .res(res), .zero(zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        p = {32'b0, x} * {32'b0, y};
        case (op)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x + y;
            3'd3: return p[31:0];
            3'd4: return y == 0 ? 32'hFFFF_FFFF : x / y;
            3'd5: return y == 0 ? x : x % y;
            3'd6: return x - y;
            default: return x < y ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic bit is_multi(input logic [2:0] op);
        return op == 3'd3 || op == 3'd4 || op == 3'd5;
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input string tag);
        int n;
        @(negedge clk);
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        start = 1'b1;
        ALUControl = op;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_lat"}, 32'(n), is_multi(op) ? 32'd32 : 32'd0);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_res"}, res, ref_alu(op, x, y));
        check({tag, "_zero"}, 32'(zero), 32'(x == y));
    endtask

    initial begin
        logic [31:0] prev, rx, ry;
        logic [2:0] rop;
        int seen;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_res", res, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        run_op(3'd2, 32'hFFFF_FFFF, 32'd1, "add_wrap");
        run_op(3'd6, 32'd5, 32'd7, "sub_neg");
        run_op(3'd7, 32'd3, 32'h8000_0000, "slt_u");
        run_op(3'd7, 32'h8000_0000, 32'd3, "slt_f");
        run_op(3'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, "and");
        run_op(3'd1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, "or");
        run_op(3'd3, 32'h0001_0001, 32'h0001_0001, "mul_sq");
        run_op(3'd3, 32'hFFFF_FFFF, 32'd2, "mul_wrap");
        run_op(3'd4, 32'd100, 32'd7, "divu");
        run_op(3'd5, 32'd100, 32'd7, "remu");
        run_op(3'd4, 32'hDEAD_BEEF, 32'd0, "div0");
        run_op(3'd5, 32'h0000_1234, 32'd0, "rem0");
        run_op(3'd1, 32'h55, 32'h55, "zero_eq");
        run_op(3'd6, 32'd1, 32'd2, "zero_ne");

        // start pulses during a multiply run must be ignored
        prev = res;
        @(negedge clk);
        start = 1'b1;
        ALUControl = 3'd3;
        a = 32'h0001_0001;
        b = 32'h0001_0001;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            check("ign_busy", 32'(busy), 32'd1);
            check("ign_hold", res, prev);
            start = i >= 3 && i <= 10;
            ALUControl = 3'd2;
            a = $urandom;
            b = $urandom;
        end
        start = 1'b0;
        @(negedge clk);
        check("ign_done", 32'(done), 32'd1);
        check("ign_res", res, 32'h0002_0001);
        @(negedge clk);
        check("ign_single", 32'(done), 32'd0);

        // back-to-back single-cycle ops with start held high
        start = 1'b1;
        ALUControl = 3'd2; a = 32'd10; b = 32'd20;
        @(negedge clk);
        check("b2b_add_done", 32'(done), 32'd1);
        check("b2b_add", res, 32'd30);
        ALUControl = 3'd6; a = 32'd10; b = 32'd20;
        @(negedge clk);
        check("b2b_sub_done", 32'(done), 32'd1);
        check("b2b_sub", res, 32'hFFFF_FFF6);
        ALUControl = 3'd1; a = 32'h0F00; b = 32'h00F0;
        @(negedge clk);
        start = 1'b0;
        check("b2b_or_done", 32'(done), 32'd1);
        check("b2b_or", res, 32'h0FF0);

        // reset in the middle of a division
        @(negedge clk);
        start = 1'b1;
        ALUControl = 3'd4; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 10; i++) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_res", res, 32'd0);
        check("mid_zero", 32'(zero), 32'd0);
        check("mid_busy0", 32'(busy), 32'd0);
        check("mid_done0", 32'(done), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen += int'(done) + int'(busy);
        end
        check("mid_quiet", 32'(seen), 32'd0);
        run_op(3'd2, 32'd2, 32'd3, "post_add");

        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            rx = $urandom;
            case ($urandom_range(0, 3))
                0: ry = 32'd0;
                1: ry = 32'($urandom_range(1, 300));
                2: ry = rx;
                default: ry = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) rx = 32'($urandom_range(0, 1000));
            run_op(rop, rx, ry, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
